fpaddsub_norm_seq: RTL and testbench

Sequential normalization stage of the FP add/sub datapath. Sits between the mantissa adder and the rounding stage. It takes the raw 27-bit aligned sum, the larger operand's exponent and the sticky bit. It produces the normalized exponent, the 23-bit mantissa and the G/R/S bits that the rounding stage consumes. Left normalization after cancellation runs iteratively, up to 4 bit positions per cycle, behind a valid/ready handshake on both sides.

---
 rtl/fpaddsub_norm_seq.sv | 143 ++++++++++++++
 tb/tb_fpaddsub_norm_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fpaddsub_norm_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpaddsub_norm_seq : FP add/sub normalization stage with iterative left
//                     shift (up to 4 positions per cycle) and valid/ready.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fpaddsub_norm_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [26:0] Sum,
    input  logic [7:0]  Ein,
    input  logic        Sin,
    input  logic        Sa,
    input  logic        Sb,
    input  logic        Ctrl,
    input  logic        MaxAB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        ZeroSum,
    output logic [8:0]  NormE,
    output logic [22:0] NormM,
    output logic        G,
    output logic        R,
    output logic        S,
    output logic        SaO,
    output logic        SbO,
    output logic        CtrlO,
    output logic        MaxABO
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic        armed;
    logic [26:0] work;
    logic [8:0]  exp_w;
    logic        sticky;
    logic        accept, carry_path, zero_path;
    logic [8:0]  lz4, exp_room, k;
    logic [26:0] work_sh;
    logic [8:0]  exp_sh;
    logic        shift_done;

    // armed keeps in_ready low until the first clock edge after reset release
    assign in_ready   = armed && (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_ready && in_valid;
    assign carry_path = Sum[26];
    assign zero_path  = (Sum == 27'd0) && !Sin;

    always_comb begin
        lz4 = 9'd4;
        if (work[25])      lz4 = 9'd0;
        else if (work[24]) lz4 = 9'd1;
        else if (work[23]) lz4 = 9'd2;
        else if (work[22]) lz4 = 9'd3;
        exp_room   = exp_w - 9'd1;
        k          = (lz4 < exp_room) ? lz4 : exp_room;
        work_sh    = work << k;
        exp_sh     = exp_w - k;
        shift_done = work_sh[25] || (exp_sh == 9'd1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (carry_path || zero_path) ? DONE : SHIFT;
            SHIFT:   if (shift_done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work    <= 27'd0;
            exp_w   <= 9'd0;
            sticky  <= 1'b0;
            ZeroSum <= 1'b0;
            NormE   <= 9'd0;
            NormM   <= 23'd0;
            G       <= 1'b0;
            R       <= 1'b0;
            S       <= 1'b0;
            SaO     <= 1'b0;
            SbO     <= 1'b0;
            CtrlO   <= 1'b0;
            MaxABO  <= 1'b0;
        end else if (accept) begin
            work    <= Sum;
            exp_w   <= (Ein == 8'd0) ? 9'd1 : {1'b0, Ein};
            sticky  <= Sin;
            SaO     <= Sa;
            SbO     <= Sb;
            CtrlO   <= Ctrl;
            MaxABO  <= MaxAB;
            ZeroSum <= zero_path;
            if (carry_path) begin
                NormE <= {1'b0, Ein} + 9'd1;
                NormM <= Sum[25:3];
                G     <= Sum[2];
                R     <= Sum[1];
                S     <= Sum[0] | Sin;
            end else begin
                // zero-path result; the shift path overwrites these on exit
                NormE <= 9'd0;
                NormM <= 23'd0;
                G     <= 1'b0;
                R     <= 1'b0;
                S     <= 1'b0;
            end
        end else if (state == SHIFT) begin
            work  <= work_sh;
            exp_w <= exp_sh;
            if (shift_done) begin
                ZeroSum <= 1'b0;
                NormE   <= work_sh[25] ? exp_sh : 9'd0;
                NormM   <= work_sh[24:2];
                G       <= work_sh[1];
                R       <= work_sh[0];
                S       <= sticky;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpaddsub_norm_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fpaddsub_norm_seq : directed table-driven bench for fpaddsub_norm_seq.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fpaddsub_norm_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [26:0] Sum = 27'd0;
    logic [7:0]  Ein = 8'd0;
    logic        Sin = 1'b0, Sa = 1'b0, Sb = 1'b0, Ctrl = 1'b0, MaxAB = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        ZeroSum;
    logic [8:0]  NormE;
    logic [22:0] NormM;
    logic        G, R, S, SaO, SbO, CtrlO, MaxABO;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpaddsub_norm_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Sum(Sum), .Ein(Ein), .Sin(Sin), .Sa(Sa), .Sb(Sb), .Ctrl(Ctrl), .MaxAB(MaxAB),
        .out_valid(out_valid), .out_ready(out_ready), .ZeroSum(ZeroSum),
        .NormE(NormE), .NormM(NormM), .G(G), .R(R), .S(S),
        .SaO(SaO), .SbO(SbO), .CtrlO(CtrlO), .MaxABO(MaxABO)
    );

    typedef struct {
        logic [26:0] sum;
        logic [7:0]  ein;
        logic        sin;
        logic [3:0]  side;   // {Sa, Sb, Ctrl, MaxAB}
        int          lat;
        logic        zero;
        logic [8:0]  e;
        logic [22:0] m;
        logic [2:0]  grs;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_result(input string tag, input vec_t v);
        chk({tag, "_zero"}, {31'd0, ZeroSum}, {31'd0, v.zero});
        chk({tag, "_NormE"}, {23'd0, NormE}, {23'd0, v.e});
        chk({tag, "_NormM"}, {9'd0, NormM}, {9'd0, v.m});
        chk({tag, "_GRS"}, {29'd0, G, R, S}, {29'd0, v.grs});
        chk({tag, "_side"}, {28'd0, SaO, SbO, CtrlO, MaxABO}, {28'd0, v.side});
    endtask

    // Drives one transaction (called #1 after a posedge) and waits for out_valid.
    task automatic issue(input string tag, input vec_t v);
        int lat;
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        Sum = v.sum; Ein = v.ein; Sin = v.sin;
        {Sa, Sb, Ctrl, MaxAB} = v.side;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        Sum = 27'h5555555; Ein = 8'hAA; Sin = 1'b1; {Sa, Sb, Ctrl, MaxAB} = ~v.side;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_latency"}, lat, v.lat);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        //           sum          ein    sin side    lat zero e       m            grs
        vecs[0] = '{27'h4000000, 8'd127, 0, 4'b0110, 1, 0, 9'd128, 23'h000000, 3'b000};
        vecs[1] = '{27'h0000004, 8'd127, 0, 4'b1001, 7, 0, 9'd104, 23'h000000, 3'b000};
        vecs[2] = '{27'h0000000, 8'd90,  0, 4'b1100, 1, 1, 9'd0,   23'h000000, 3'b000};
        vecs[3] = '{27'h0400000, 8'd2,   0, 4'b0011, 2, 0, 9'd0,   23'h200000, 3'b000};
        vecs[4] = '{27'h4000001, 8'd255, 0, 4'b1010, 1, 0, 9'h100, 23'h000000, 3'b001};
        vecs[5] = '{27'h2ABCDEF, 8'd100, 1, 4'b0101, 2, 0, 9'd100, 23'h2AF37B, 3'b111};
        vecs[6] = '{27'h0100003, 8'd50,  0, 4'b1111, 3, 0, 9'd45,  23'h000018, 3'b000};
        vecs[7] = '{27'h0000010, 8'd0,   0, 4'b0001, 2, 0, 9'd0,   23'h000004, 3'b000};
        vecs[8] = '{27'h0000000, 8'd3,   1, 4'b1000, 2, 0, 9'd0,   23'h000000, 3'b001};
        vecs[9] = '{27'h7FFFFFF, 8'd10,  0, 4'b0100, 1, 0, 9'd11,  23'h7FFFFF, 3'b111};

        // reset state
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_outputs", {ZeroSum, NormE, NormM, G, R, S, SaO, SbO, CtrlO, MaxABO},
            32'd0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_release_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("first_edge_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            issue(tag, vecs[i]);
            check_result(tag, vecs[i]);
            handshake();
            chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        end

        // backpressure: hold DONE for 5 cycles while offering a new transaction
        issue("bp", vecs[5]);
        Sum = 27'h4000000; Ein = 8'd7; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid_c%0d", c), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp_in_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
            check_result($sformatf("bp_c%0d", c), vecs[5]);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_after_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_after_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_ghost", {31'd0, out_valid}, 32'd0);

        // reset in the middle of a long SHIFT sequence
        Sum = vecs[1].sum; Ein = vecs[1].ein; Sin = 1'b0; {Sa, Sb, Ctrl, MaxAB} = 4'b1111;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_no_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs", {ZeroSum, NormE, NormM, G, R, S, SaO, SbO, CtrlO, MaxABO},
            32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        begin
            int seen = 0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            chk("mid_rst_aborted", seen, 0);
        end
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        issue("post_rst", vecs[6]);
        check_result("post_rst", vecs[6]);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
